dct_pingpong_seq: RTL and testbench
===================================

Name: dct_pingpong_seq

Overview:
- Sequencer for the two-bank (ping-pong) 8x8 transpose buffer between the row DCT and the column DCT stages of the 2D DCT path.
- Accepts a 64-sample block stream from the row DCT with a valid/ready handshake and generates write enables and write addresses for one bank.
- At the same time it drains the other, previously filled bank, generating read enables and read addresses.
- Presents valid/first/last framing to the column DCT, so the two stages overlap and sustain one sample per clock.

Parameters:
TRANSPOSE, 1, 1: write column-major, read row-major (transpose); 0: both row-major (plain block delay)
CNT_W, 16, width of the completed-block counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream sample valid
in_ready  out  1  sequencer can accept a sample this cycle
wr_en  out  1  bank write strobe (= in_valid & in_ready)
wr_bank  out  1  bank being written
wr_row  out  3  write row index
wr_col  out  3  write column index
rd_en  out  1  bank read strobe
rd_bank  out  1  bank being read
rd_row  out  3  read row index
rd_col  out  3  read column index
out_valid  out  1  buffer read data valid toward column DCT
out_ready  in  1  downstream accepts sample
out_first  out  1  sample 0 of block, qualified by out_valid
out_last  out  1  sample 63 of block, qualified by out_valid
blk_done  out  1  one-cycle pulse when sample 63 of a block is accepted downstream
full  out  2  per-bank full flags (bit i = bank i)
blk_count  out  CNT_W  completed blocks, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at clk edge):
  - wcnt=0, rcnt=0, wb=0, rb=0, full=2'b00.
  - out_valid=0, out_first=0, out_last=0, blk_done=0, blk_count=0.
  - Any partial block is discarded. Reset takes priority over every other event.
- in_ready = ~full[wb] (combinational from registers). wr_en = in_valid & in_ready. wr_bank = wb.
- Write addressing, 6-bit counter wcnt:
  - TRANSPOSE=1: wr_row = wcnt[2:0], wr_col = wcnt[5:3].
  - TRANSPOSE=0: wr_row = wcnt[5:3], wr_col = wcnt[2:0].
- On each wr_en, wcnt increments. On the wr_en with wcnt=63: wcnt wraps to 0, full[wb] is set, wb toggles.
- Read side:
  - rd_en = full[rb] & (~out_valid | out_ready). rd_bank = rb.
  - rd_row = rcnt[5:3], rd_col = rcnt[2:0].
  - On each rd_en, rcnt increments. On the rd_en with rcnt=63: rcnt wraps, full[rb] is cleared, rb toggles.
- The buffer memory has a registered read port: data appears one cycle after rd_en and holds until the next rd_en.
- out_valid register:
  - set on rd_en;
  - cleared when out_ready & ~rd_en;
  - held while out_valid & ~out_ready (stall: rd_en=0, addresses frozen, out_first/out_last held).
- out_first / out_last are registered with rd_en from rcnt==0 / rcnt==63.
- blk_done = out_valid & out_ready & out_last. blk_count increments on blk_done.
- Latency: 64th sample accepted in cycle N gives rd_en in N+1 and first out_valid in N+2.
- Throughput: steady state is 1 sample/clk with no bubbles when in_valid and out_ready are held high.
- Boundary conditions:
  - Both banks full: in_ready=0 until the drain of bank rb completes. The freed bank is writable the cycle after its flag clears.
  - Fill of bank X completing in the same cycle as the drain of bank Y completing: both flag updates apply.
  - The same bank can never complete fill and drain in one cycle.
  - in_valid with in_ready=0: no write, counters hold.

Test Plan:
- Reset, then 64 samples with in_valid=1 and out_ready=1:
  - wr addresses follow (0,0),(1,0)..(7,0),(0,1)..(7,7);
  - rd_en in cycle 65 (counting from the first accepted sample as cycle 1) with rd addresses (0,0),(0,1)..(7,7);
  - out_first on the first out_valid, out_last 63 cycles later;
  - blk_done once, blk_count=1.
- 3 back-to-back blocks, continuous valid/ready -> in_ready never drops, out_valid continuous for 192 cycles after the first, wr_bank/rd_bank alternate 0,1,0, blk_count=3.
- out_ready=0 for 200 cycles after 2 full blocks written -> full=2'b11, in_ready=0, out_valid held with address frozen; release out_ready -> sequence resumes without loss or duplication.
- out_ready toggling 1,0 every cycle -> each coefficient index 0..63 is delivered exactly once, in order.
- Assert rst after 30 samples of a block and mid-drain -> all outputs at reset values the next cycle; a new block then starts at wcnt=0 in bank 0.
- TRANSPOSE=0, single block -> write and read addresses both row-major, identical order.

Source files
------------

// File: rtl/dct_pingpong_seq.sv
// Ping-pong transpose-buffer sequencer between row and column DCT stages.
// One bank fills from upstream while the other drains toward the column DCT.
module dct_pingpong_seq #(
  parameter int TRANSPOSE = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [2:0]       wr_row,
  output logic [2:0]       wr_col,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [2:0]       rd_row,
  output logic [2:0]       rd_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             blk_done,
  output logic [1:0]       full,
  output logic [CNT_W-1:0] blk_count
);

  logic [5:0]       wcnt_q, wcnt_d;
  logic [5:0]       rcnt_q, rcnt_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [1:0]       full_q, full_d;
  logic             ov_q, ov_d;
  logic             of_q, of_d;
  logic             ol_q, ol_d;
  logic [CNT_W-1:0] bc_q, bc_d;

  assign in_ready  = ~full_q[wb_q];
  assign wr_en     = in_valid & in_ready;
  assign wr_bank   = wb_q;
  assign rd_en     = full_q[rb_q] & (~ov_q | out_ready);
  assign rd_bank   = rb_q;
  assign rd_row    = rcnt_q[5:3];
  assign rd_col    = rcnt_q[2:0];
  assign out_valid = ov_q;
  assign out_first = of_q;
  assign out_last  = ol_q;
  assign blk_done  = ov_q & out_ready & ol_q;
  assign full      = full_q;
  assign blk_count = bc_q;

  // Transposing writes column-major; the read side is always row-major.
  generate
    if (TRANSPOSE != 0) begin : g_tr
      assign wr_row = wcnt_q[2:0];
      assign wr_col = wcnt_q[5:3];
    end else begin : g_plain
      assign wr_row = wcnt_q[5:3];
      assign wr_col = wcnt_q[2:0];
    end
  endgenerate

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    full_d = full_q;
    ov_d   = ov_q;
    of_d   = of_q;
    ol_d   = ol_q;
    bc_d   = bc_q;

    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end

    // wr_en needs ~full[wb] and rd_en needs full[rb], so these never hit the same bank.
    if (rd_en) begin
      rcnt_d = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end

    if (rd_en) begin
      ov_d = 1'b1;
      of_d = (rcnt_q == 6'd0);
      ol_d = (rcnt_q == 6'd63);
    end else if (out_ready) begin
      ov_d = 1'b0;
    end

    if (blk_done) bc_d = bc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      full_q <= 2'b00;
      ov_q   <= 1'b0;
      of_q   <= 1'b0;
      ol_q   <= 1'b0;
      bc_q   <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      full_q <= full_d;
      ov_q   <= ov_d;
      of_q   <= of_d;
      ol_q   <= ol_d;
      bc_q   <= bc_d;
    end
  end

endmodule

// File: tb/tb_dct_pingpong_seq.sv
// Self-checking bench for dct_pingpong_seq: block-level reference model plus
// an emulated buffer memory that tracks which sample reaches the column side.
module tb_dct_pingpong_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready, wr_en, wr_bank, rd_en, rd_bank, out_valid, out_first, out_last, blk_done;
  logic [2:0] wr_row, wr_col, rd_row, rd_col;
  logic [1:0] full;
  logic [15:0] blk_count;

  logic in_ready0, wr_en0, wr_bank0, rd_en0, rd_bank0, out_valid0, out_first0, out_last0, blk_done0;
  logic [2:0] wr_row0, wr_col0, rd_row0, rd_col0;
  logic [1:0] full0;
  logic [15:0] blk_count0;

  int tests_run = 0;
  int tests_failed = 0;

  dct_pingpong_seq #(.TRANSPOSE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last), .blk_done(blk_done), .full(full), .blk_count(blk_count)
  );

  dct_pingpong_seq #(.TRANSPOSE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .wr_en(wr_en0), .wr_bank(wr_bank0), .wr_row(wr_row0), .wr_col(wr_col0),
    .rd_en(rd_en0), .rd_bank(rd_bank0), .rd_row(rd_row0), .rd_col(rd_col0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_first(out_first0),
    .out_last(out_last0), .blk_done(blk_done0), .full(full0), .blk_count(blk_count0)
  );

  always #5 clk = ~clk;

  // Reference model: wn = samples written, rn = samples read, dn = samples delivered.
  int wn = 0, rn = 0, dn = 0;
  bit mon_en = 1'b0;
  int mem [2][64];
  int data_tag = 0;

  always @(negedge clk) begin
    int  wblk, rblk, j, k, exp_tag, next_tag;
    bit  exp_ir, exp_wr, exp_rd, pend, deliver;
    logic [1:0] exp_full;
    if (rst) begin
      wn = 0; rn = 0; dn = 0;
    end else if (mon_en) begin
      wblk = wn / 64;
      rblk = rn / 64;
      pend = (rn != dn);
      exp_ir = (wblk - rblk) < 2;
      exp_wr = in_valid && exp_ir;
      exp_rd = (wblk > rblk) && (!pend || out_ready);
      deliver = pend && out_ready;
      exp_full = 2'b00;
      for (int b = rblk; b < wblk; b++) exp_full[b % 2] = 1'b1;
      next_tag = data_tag;

      tests_run++;
      if (in_ready !== exp_ir) begin tests_failed++; $display("FAIL in_ready: got %b exp %b", in_ready, exp_ir); end
      tests_run++;
      if (wr_en !== exp_wr || wr_en0 !== exp_wr) begin tests_failed++; $display("FAIL wr_en: got %b/%b exp %b", wr_en, wr_en0, exp_wr); end
      tests_run++;
      if (rd_en !== exp_rd || rd_en0 !== exp_rd) begin tests_failed++; $display("FAIL rd_en: got %b/%b exp %b", rd_en, rd_en0, exp_rd); end
      tests_run++;
      if (out_valid !== pend) begin tests_failed++; $display("FAIL out_valid: got %b exp %b", out_valid, pend); end
      tests_run++;
      if (full !== exp_full) begin tests_failed++; $display("FAIL full: got %b exp %b", full, exp_full); end
      tests_run++;
      if (blk_count !== 16'(dn / 64)) begin tests_failed++; $display("FAIL blk_count: got %0d exp %0d", blk_count, dn / 64); end

      if (exp_wr) begin
        k = wn % 64;
        tests_run++;
        if (wr_bank !== 1'((wn / 64) % 2) || wr_row !== 3'(k % 8) || wr_col !== 3'(k / 8))
          begin tests_failed++; $display("FAIL wr_addr: got b%0d r%0d c%0d exp b%0d r%0d c%0d", wr_bank, wr_row, wr_col, (wn/64)%2, k%8, k/8); end
        tests_run++;
        if (wr_row0 !== 3'(k / 8) || wr_col0 !== 3'(k % 8))
          begin tests_failed++; $display("FAIL wr_addr_plain: got r%0d c%0d exp r%0d c%0d", wr_row0, wr_col0, k/8, k%8); end
        mem[wr_bank][{wr_row, wr_col}] = wn;
      end

      if (exp_rd) begin
        j = rn % 64;
        tests_run++;
        if (rd_bank !== 1'((rn / 64) % 2) || rd_row !== 3'(j / 8) || rd_col !== 3'(j % 8) ||
            rd_row0 !== 3'(j / 8) || rd_col0 !== 3'(j % 8))
          begin tests_failed++; $display("FAIL rd_addr: got b%0d r%0d c%0d exp b%0d r%0d c%0d", rd_bank, rd_row, rd_col, (rn/64)%2, j/8, j%8); end
        next_tag = mem[rd_bank][{rd_row, rd_col}];
      end

      if (deliver) begin
        j = dn % 64;
        exp_tag = (dn / 64) * 64 + (j % 8) * 8 + j / 8;
        tests_run++;
        if (data_tag !== exp_tag) begin tests_failed++; $display("FAIL out_sample: got %0d exp %0d", data_tag, exp_tag); end
        tests_run++;
        if (out_first !== (j == 0) || out_last !== (j == 63) || blk_done !== (j == 63))
          begin tests_failed++; $display("FAIL framing: got f%b l%b d%b exp idx %0d", out_first, out_last, blk_done, j); end
        dn++;
      end else begin
        tests_run++;
        if (blk_done !== 1'b0) begin tests_failed++; $display("FAIL blk_done_idle: got %b exp 0", blk_done); end
      end

      if (exp_wr) wn++;
      if (exp_rd) begin rn++; data_tag = next_tag; end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || full !== 2'b00 || wr_bank !== 1'b0 || rd_bank !== 1'b0)
      begin tests_failed++; $display("FAIL reset_ctl: got ir%b full%b wb%b rb%b exp 1 00 0 0", in_ready, full, wr_bank, rd_bank); end
    tests_run++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || blk_done !== 1'b0 || blk_count !== 16'd0 || rd_en !== 1'b0)
      begin tests_failed++; $display("FAIL reset_out: got ov%b f%b l%b d%b cnt%0d rd%b exp all 0", out_valid, out_first, out_last, blk_done, blk_count, rd_en); end
    step();
  endtask

  task automatic test_single_block();
    int first_rd = 0, first_ov = 0, last_cyc = 0, dones = 0;
    bit  first_ok = 1'b0;
    apply_reset();
    for (int cyc = 1; cyc <= 200; cyc++) begin
      in_valid = (cyc <= 64);
      @(negedge clk); #1;
      if (rd_en && first_rd == 0) first_rd = cyc;
      if (out_valid && first_ov == 0) begin first_ov = cyc; first_ok = out_first; end
      if (out_valid && out_last && last_cyc == 0) last_cyc = cyc;
      if (blk_done) dones++;
      step();
    end
    tests_run++;
    if (first_rd !== 65) begin tests_failed++; $display("FAIL first_rd_cycle: got %0d exp 65", first_rd); end
    tests_run++;
    if (first_ov !== 66 || first_ok !== 1'b1) begin tests_failed++; $display("FAIL first_out: got cyc %0d first %b exp 66 1", first_ov, first_ok); end
    tests_run++;
    if (last_cyc !== 129) begin tests_failed++; $display("FAIL last_out_cycle: got %0d exp 129", last_cyc); end
    tests_run++;
    if (dones !== 1 || blk_count !== 16'd1) begin tests_failed++; $display("FAIL single_done: got %0d/%0d exp 1/1", dones, blk_count); end
  endtask

  task automatic test_back_to_back();
    int ir_drop = 0, gaps = 0;
    int banks[$];
    apply_reset();
    for (int cyc = 1; cyc <= 300; cyc++) begin
      in_valid = (cyc <= 192);
      @(negedge clk); #1;
      if (in_valid && !in_ready) ir_drop++;
      if (cyc >= 66 && cyc < 66 + 192 && !out_valid) gaps++;
      if (rd_en && rd_row == 3'd0 && rd_col == 3'd0) banks.push_back(int'(rd_bank));
      step();
    end
    tests_run++;
    if (ir_drop !== 0 || gaps !== 0) begin tests_failed++; $display("FAIL b2b_bubbles: got drops %0d gaps %0d exp 0 0", ir_drop, gaps); end
    tests_run++;
    if (banks.size() !== 3 || banks[0] !== 0 || banks[1] !== 1 || banks[2] !== 0)
      begin tests_failed++; $display("FAIL b2b_banks: got n%0d exp 0,1,0", banks.size()); end
    tests_run++;
    if (blk_count !== 16'd3) begin tests_failed++; $display("FAIL b2b_count: got %0d exp 3", blk_count); end
  endtask

  task automatic test_stall();
    logic [2:0] r100 = '0, c100 = '0;
    apply_reset();
    out_ready = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      in_valid = 1'b1;
      @(negedge clk); #1;
      if (cyc == 100) begin r100 = rd_row; c100 = rd_col; end
      if (cyc != 200) step();
    end
    tests_run++;
    if (full !== 2'b11 || in_ready !== 1'b0 || out_valid !== 1'b1 || rd_en !== 1'b0 || out_first !== 1'b1)
      begin tests_failed++; $display("FAIL stall_state: got full%b ir%b ov%b rd%b f%b exp 11 0 1 0 1", full, in_ready, out_valid, rd_en, out_first); end
    tests_run++;
    if (rd_row !== r100 || rd_col !== c100 || rd_row !== 3'd0 || rd_col !== 3'd1)
      begin tests_failed++; $display("FAIL stall_addr: got r%0d c%0d exp r0 c1", rd_row, rd_col); end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (200) step();
    tests_run++;
    if (blk_count !== 16'd2 || full !== 2'b00 || dn !== 128)
      begin tests_failed++; $display("FAIL stall_resume: got cnt %0d full %b dn %0d exp 2 00 128", blk_count, full, dn); end
  endtask

  task automatic test_toggle();
    apply_reset();
    for (int cyc = 1; cyc <= 250; cyc++) begin
      in_valid = (cyc <= 64);
      out_ready = cyc[0];
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (blk_count !== 16'd1 || dn !== 64) begin tests_failed++; $display("FAIL toggle_done: got cnt %0d dn %0d exp 1 64", blk_count, dn); end
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (300) step();
    @(negedge clk); #1;
    tests_run++;
    if (blk_count !== 16'(wn / 64) || full !== 2'b00 || wn < 640)
      begin tests_failed++; $display("FAIL random_drain: got cnt %0d full %b exp %0d 00 (wn %0d)", blk_count, full, wn / 64, wn); end
    step();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    in_valid = 1'b1;
    repeat (30) step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (full !== 2'b00 || in_ready !== 1'b1 || wr_bank !== 1'b0 || out_valid !== 1'b0)
      begin tests_failed++; $display("FAIL rst_fill: got full%b ir%b wb%b ov%b exp 00 1 0 0", full, in_ready, wr_bank, out_valid); end
    step();
    in_valid = 1'b1;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || blk_done !== 1'b0 ||
        blk_count !== 16'd0 || full !== 2'b00 || rd_en !== 1'b0 || wr_bank !== 1'b0 || rd_bank !== 1'b0)
      begin tests_failed++; $display("FAIL rst_drain: got ov%b cnt%0d full%b rd%b wb%b rb%b exp 0 0 00 0 0 0", out_valid, blk_count, full, rd_en, wr_bank, rd_bank); end
    step();
    in_valid = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (wr_en !== 1'b1 || wr_bank !== 1'b0 || wr_row !== 3'd0 || wr_col !== 3'd0)
      begin tests_failed++; $display("FAIL rst_restart: got en%b b%0d r%0d c%0d exp 1 0 0 0", wr_en, wr_bank, wr_row, wr_col); end
    step();
    repeat (63) step();
    in_valid = 1'b0;
    repeat (100) step();
    tests_run++;
    if (blk_count !== 16'd1) begin tests_failed++; $display("FAIL rst_newblk: got %0d exp 1", blk_count); end
  endtask

  task automatic test_transpose0();
    int wq[$], rq[$];
    int bad = 0;
    apply_reset();
    for (int cyc = 1; cyc <= 160; cyc++) begin
      in_valid = (cyc <= 64);
      @(negedge clk); #1;
      if (wr_en0) wq.push_back(int'({wr_row0, wr_col0}));
      if (rd_en0) rq.push_back(int'({rd_row0, rd_col0}));
      step();
    end
    for (int i = 0; i < 64 && i < wq.size() && i < rq.size(); i++)
      if (wq[i] != i || rq[i] != i) bad++;
    tests_run++;
    if (wq.size() !== 64 || rq.size() !== 64 || bad !== 0)
      begin tests_failed++; $display("FAIL plain_order: got wr %0d rd %0d bad %0d exp 64 64 0", wq.size(), rq.size(), bad); end
    tests_run++;
    if (blk_count0 !== 16'd1 || full0 !== 2'b00) begin tests_failed++; $display("FAIL plain_done: got %0d %b exp 1 00", blk_count0, full0); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_random();
    test_mid_reset();
    test_transpose0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
